// File: rtl/ram2_arbiter.sv
// ram2_arbiter
//   Shares a single ram2 (32x32, ena/wena/addr plus a bidirectional data bus) between
//   two requesters. The block arbitrates round-robin, sequences each RAM access and
//   owns the tristate drive of the shared bus. Every transaction returns a one-cycle
//   ack; reads also return data on rdata.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN    requester N command; held stable until ackN
//   ackN                     one-cycle completion pulse to requester N
//   rdataN                   last read data for requester N; valid with ackN, held after
//   ram_ena/ram_wena         ram2 enable / write enable (1 = write)
//   ram_addr                 ram2 word address; holds its last value while idle
//   ram_data                 shared ram2 data bus; driven only while writing
//   busy                     high whenever a transaction is in flight
//
// Every output comes from a flop or is decoded from the state register, so nothing
// on the request side reaches the RAM pins combinationally.
module ram2_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  inout  wire  [DW-1:0] ram_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR     = 2'd1,
    RD     = 2'd2,
    RD_CAP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;  // requester index granted most recently
  logic          owner_q, owner_d;            // requester owning the current access
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Requester ports gathered into indexable form.
  logic [1:0]    req_w;
  logic [1:0]    we_w;
  logic [1:0]    ack_w;
  logic [AW-1:0] addr_w  [2];
  logic [DW-1:0] wdata_w [2];
  logic [DW-1:0] rdata_w [2];

  logic [1:0]    elig;
  logic          pick;
  logic          done;
  logic          cap;

  assign req_w      = {req1, req0};
  assign we_w       = {we1, we0};
  assign addr_w[0]  = addr0;
  assign addr_w[1]  = addr1;
  assign wdata_w[0] = wdata0;
  assign wdata_w[1] = wdata1;

  // A requester whose ack is high this cycle has not yet had a chance to drop req,
  // so it is masked out to avoid granting the same transaction twice.
  assign elig = req_w & ~ack_w;

  // The access finishes at the end of WR or RD_CAP; the ack appears one cycle later.
  assign done = (state_q == WR) || (state_q == RD_CAP);
  assign cap  = (state_q == RD_CAP);

  // Round-robin pick: on a tie, the requester that was not granted last wins.
  always_comb begin
    pick = 1'b0;
    if (elig == 2'b11) begin
      pick = ~last_grant_q;
    end else begin
      pick = elig[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          owner_d      = pick;
          last_grant_d = pick;
          addr_d       = addr_w[pick];
          wdata_d      = wdata_w[pick];
          state_d      = we_w[pick] ? WR : RD;
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = RD_CAP;
      RD_CAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // requester 0 wins the first tie after reset
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Per-requester completion flops: ack pulse and read-data holding register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          mine;

    assign mine = (owner_q == 1'(gi));

    always_comb begin
      ack_d   = done & mine;
      rdata_d = rdata_q;
      // Two-cycle read: the bus has settled by the end of RD_CAP whether the RAM
      // reads asynchronously or on the clock.
      if (cap && mine) begin
        rdata_d = ram_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ack_q   <= 1'b0;
        rdata_q <= '0;
      end else begin
        ack_q   <= ack_d;
        rdata_q <= rdata_d;
      end
    end

    assign ack_w[gi]   = ack_q;
    assign rdata_w[gi] = rdata_q;
  end

  assign ack0   = ack_w[0];
  assign ack1   = ack_w[1];
  assign rdata0 = rdata_w[0];
  assign rdata1 = rdata_w[1];

  // RAM side, decoded purely from the state register and command flops.
  assign ram_ena  = (state_q != IDLE);
  assign ram_wena = (state_q == WR);
  assign ram_addr = addr_q;
  assign busy     = (state_q != IDLE);

  // Bus driven only during WR; every RD is entered from IDLE, so there is always
  // at least one undriven cycle before the RAM drives read data.
  assign ram_data = (state_q == WR) ? wdata_q : {DW{1'bz}};

endmodule
